img_window_fetch_ctrl: RTL

Sequences Avalon-MM reads of a row-major 32-bit-per-pixel image to feed a 3x3 window datapath.
- Latches image dimensions (n_colum, n_row) and base address on start.
- For each interior output row, walks every column and fetches the top, mid and bottom pixel words.
- Presents each fetched 3-pixel column on a valid/ready stream.
- Sits between the image-spec register block and the Avalon-MM read master port.

---
 rtl/img_window_fetch_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/img_window_fetch_ctrl.sv
// Read sequencer for a 3x3 window datapath: for every interior pixel column it
// fetches the pixels above, at and below it over Avalon-MM and streams the triple out.
module img_window_fetch_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0800_0000,
  parameter int unsigned PIX_BYTES = 4
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [15:0] n_colum,
  input  logic [15:0] n_row,
  output logic [31:0] avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        col_valid,
  input  logic        col_ready,
  output logic [31:0] col_top,
  output logic [31:0] col_mid,
  output logic [31:0] col_bot,
  output logic        col_last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned PIX_SH   = $clog2(PIX_BYTES);
  localparam logic [31:0] PIX_STEP = 32'(PIX_BYTES);

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_EMIT, ST_DONE} state_t;

  state_t      state;
  logic [15:0] ncol;
  logic [15:0] nrow;
  logic [15:0] col;
  logic [15:0] row_cnt;
  logic [1:0]  lane;
  logic [31:0] row_base;
  logic [31:0] col_off;
  logic [31:0] stride;
  logic        col_is_last;
  logic        row_is_last;

  // One image row in bytes; the lane offset is reached by adding this per fetch.
  assign stride      = 32'(ncol) << PIX_SH;
  assign col_is_last = (col == ncol - 16'd1);
  assign row_is_last = (row_cnt == nrow - 16'd3);

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      avm_address <= '0;
      col_valid   <= 1'b0;
      col_top     <= '0;
      col_mid     <= '0;
      col_bot     <= '0;
      col_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      lane        <= '0;
      col         <= '0;
      row_cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (n_colum != 16'd0 && n_row >= 16'd3) begin
              ncol        <= n_colum;
              nrow        <= n_row;
              row_base    <= BASE_ADDR;
              col_off     <= '0;
              col         <= '0;
              lane        <= '0;
              row_cnt     <= '0;
              busy        <= 1'b1;
              avm_address <= BASE_ADDR;
              avm_read    <= 1'b1;
              state       <= ST_REQ;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (!avm_waitrequest) begin
            avm_read <= 1'b0;
            state    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (avm_readdatavalid) begin
            case (lane)
              2'd0:    col_top <= avm_readdata;
              2'd1:    col_mid <= avm_readdata;
              default: col_bot <= avm_readdata;
            endcase
            if (lane != 2'd2) begin
              lane        <= lane + 2'd1;
              avm_address <= avm_address + stride;
              avm_read    <= 1'b1;
              state       <= ST_REQ;
            end else begin
              col_valid <= 1'b1;
              col_last  <= col_is_last;
              state     <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (col_ready) begin
            col_valid <= 1'b0;
            col_last  <= 1'b0;
            lane      <= '0;
            if (!col_is_last) begin
              col         <= col + 16'd1;
              col_off     <= col_off + PIX_STEP;
              avm_address <= row_base + col_off + PIX_STEP;
              avm_read    <= 1'b1;
              state       <= ST_REQ;
            end else if (!row_is_last) begin
              col         <= '0;
              col_off     <= '0;
              row_base    <= row_base + stride;
              row_cnt     <= row_cnt + 16'd1;
              avm_address <= row_base + stride;
              avm_read    <= 1'b1;
              state       <= ST_REQ;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
